// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes,
// ALU encodings, decoded instruction class and per-state control bundle.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   typedef enum logic [2:0] {
      C_R     = 3'd0,
      C_I     = 3'd1,
      C_LOAD  = 3'd2,
      C_STORE = 3'd3,
      C_BAD   = 3'd4
   } op_class_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   function automatic op_class_t decode_op(input logic [6:0] op);
      op_class_t c;
      case (op)
         OPC_R:     c = C_R;
         OPC_I:     c = C_I;
         OPC_LOAD:  c = C_LOAD;
         OPC_STORE: c = C_STORE;
         default:   c = C_BAD;
      endcase
      return c;
   endfunction

   // Moore part of the control word; anything not named for a state stays 0.
   function automatic ctrl_t ctrl_for(input state_t st, input op_class_t c);
      ctrl_t k;
      k = '0;
      case (st)
         S_FETCH: begin
            k.mem_req   = 1'b1;
            k.alu_src_b = SRCB_FOUR;
            k.alu_op    = ALU_ADD;
         end
         S_EXEC: begin
            k.alu_src_a = 1'b1;
            case (c)
               C_R: begin
                  k.alu_src_b = SRCB_RS2;
                  k.alu_op    = ALU_FUNCT;
               end
               C_I: begin
                  k.alu_src_b = SRCB_IMM;
                  k.alu_op    = ALU_FUNCT;
               end
               default: begin
                  k.alu_src_b = SRCB_IMM;
                  k.alu_op    = ALU_ADD;
               end
            endcase
         end
         S_MEM: begin
            k.mem_req = 1'b1;
            k.i_or_d  = 1'b1;
            k.mem_we  = (c == C_STORE);
         end
         S_WB: begin
            k.reg_write  = 1'b1;
            k.mem_to_reg = (c == C_LOAD);
         end
         default: k = '0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle that would reach
// WAIT_MAX; the count clears whenever waiting stops (i.e. on a state change).
module mc_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);

   logic [CW-1:0] cnt_r;

   assign expired = count_en && (cnt_r == LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (!count_en || expired) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with wait timeout.
// Optional retired-instruction counter enabled by macro MC_PERF_CNT_EN.
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        i_or_d,
   output logic        pc_write,
   output logic        ir_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic        timeout,
   output logic [2:0]  state,
   output logic [31:0] retired_cnt
);

   state_t    state_r, state_nxt;
   op_class_t cls_r, cls_nxt;
   ctrl_t     ctrl_r;
   logic      illegal_r, timeout_r;
   logic      waiting, expired;

   assign waiting = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;

   mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .count_en (waiting),
      .expired  (expired)
   );

   // mem_ready is checked before expiry so a late completion still wins.
   always_comb begin
      state_nxt = state_r;
      cls_nxt   = cls_r;
      case (state_r)
         S_FETCH: begin
            if (mem_ready)    state_nxt = S_DECODE;
            else if (expired) state_nxt = S_ERR;
            else              state_nxt = S_FETCH;
         end
         S_DECODE: begin
            cls_nxt = decode_op(opcode);
            if (cls_nxt == C_BAD) state_nxt = S_ERR;
            else                  state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if ((cls_r == C_R) || (cls_r == C_I)) state_nxt = S_WB;
            else                                  state_nxt = S_MEM;
         end
         S_MEM: begin
            if (mem_ready) begin
               if (cls_r == C_STORE) state_nxt = S_FETCH;
               else                  state_nxt = S_WB;
            end else if (expired) begin
               state_nxt = S_ERR;
            end else begin
               state_nxt = S_MEM;
            end
         end
         S_WB:    state_nxt = S_FETCH;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_ERR;
      endcase
   end

   // Control word is registered from the next state so it is valid on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_FETCH;
         cls_r     <= C_R;
         ctrl_r    <= ctrl_for(S_FETCH, C_R);
         illegal_r <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r <= state_nxt;
         cls_r   <= cls_nxt;
         ctrl_r  <= ctrl_for(state_nxt, cls_nxt);
         if ((state_r == S_DECODE) && (state_nxt == S_ERR)) begin
            illegal_r <= 1'b1;
         end
         if (((state_r == S_FETCH) || (state_r == S_MEM)) && (state_nxt == S_ERR)) begin
            timeout_r <= 1'b1;
         end
      end
   end

   assign mem_req    = ctrl_r.mem_req;
   assign mem_we     = ctrl_r.mem_we;
   assign i_or_d     = ctrl_r.i_or_d;
   assign alu_src_a  = ctrl_r.alu_src_a;
   assign alu_src_b  = ctrl_r.alu_src_b;
   assign alu_op     = ctrl_r.alu_op;
   assign reg_write  = ctrl_r.reg_write;
   assign mem_to_reg = ctrl_r.mem_to_reg;
   assign illegal    = illegal_r;
   assign timeout    = timeout_r;
   assign state      = state_r;

   // Fetch completion strobes follow mem_ready in the same cycle.
   assign ir_write = (state_r == S_FETCH) && mem_ready && !reset;
   assign pc_write = (state_r == S_FETCH) && mem_ready && !reset;

`ifdef MC_PERF_CNT_EN
   logic [31:0] retired_r;

   // Retire on leaving WB, or when a store completes in MEM.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_r <= 32'd0;
      end else if ((state_r == S_WB) ||
                   ((state_r == S_MEM) && (cls_r == C_STORE) && mem_ready)) begin
         retired_r <= retired_r + 32'd1;
      end
   end

   assign retired_cnt = retired_r;
`else
   assign retired_cnt = 32'd0;
`endif

endmodule
